key_scan: RTL
=============

Name: key_scan

Overview:
- Front-end stage for the front-panel keys. Feeds the key deframer directly.
- Synchronises the raw active-low key lines and debounces them on a slow sample tick.
- Emits one-cycle key_data/key_data_valid events on each accepted press pattern, with optional auto-repeat while a key is held.
- key_data[4:0] carries the raw active-low pattern; for example, key 0 alone gives 5'h1e.

Parameters:
- U_DLY, 1: simulation delay on register assignments.
- KEY_NUM, 5: number of key lines, 1..16.
- SAMPLE_DIV, 50000: clk_sys cycles per sample tick (1 ms at 50 MHz); minimum 2.
- DEBOUNCE_N, 20: consecutive identical samples required to accept a new level; minimum 2.
- REPEAT_DLY, 500: ticks a pattern must be held before the first repeat event; 0 disables repeat.
- REPEAT_PERIOD, 100: ticks between repeat events; minimum 1.

Ports:
- clk_sys, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-high.
- key_in, input, KEY_NUM: raw key lines, asynchronous, active-low (0 = pressed).
- key_state, output, KEY_NUM: debounced level, active-low.
- key_data, output, 16: event word {(16-KEY_NUM) ones, debounced pattern}; held between events.
- key_data_valid, output, 1: one-cycle strobe qualifying key_data.

Behaviour:
- Clocking: one clock, clk_sys. Reset is synchronous and active-high: every register is cleared on the clk_sys edge where rst=1.
- Reset values:
  - key_state = all ones; key_data = 16'hffff; key_data_valid = 0.
  - Sync flops = all ones; candidate = all ones; debounce count = 0; tick divider = 0; FSM = IDLE.
- Synchroniser: 2-flop chain on key_in, giving sync_key.
- Tick divider:
  - Counts 0..SAMPLE_DIV-1 and wraps to 0.
  - tick=1 for one cycle when count = SAMPLE_DIV-1.
  - Free-running from reset.
- Debounce, evaluated only on tick:
  - If sync_key != candidate: candidate <= sync_key, dcnt <= 0.
  - Else if dcnt < DEBOUNCE_N-1: dcnt <= dcnt+1.
  - When dcnt = DEBOUNCE_N-1 and candidate != key_state: key_state <= candidate.
  - Net effect: a new level is accepted on the DEBOUNCE_N-th consecutive tick that samples it.
  - Any glitch shorter than DEBOUNCE_N-1 ticks leaves key_state unchanged.
- Event FSM. Define chg = key_state updated this cycle; rel = (new key_state == all ones).
  - IDLE:
    - On chg with !rel: emit event, load rcnt = REPEAT_DLY, go to HOLD.
  - HOLD (pattern held, no repeat yet):
    - On chg with rel: go to IDLE, no event.
    - On chg with !rel: emit event for the new pattern, reload rcnt = REPEAT_DLY, stay in HOLD.
    - Else, on tick with REPEAT_DLY != 0: decrement rcnt. On reaching 0: emit event, load rcnt = REPEAT_PERIOD, go to REPT.
  - REPT:
    - Change handling is identical to HOLD; a pattern change returns to HOLD.
    - On tick, rcnt decrements. On reaching 0: emit event, reload REPEAT_PERIOD.
- Emit: on the cycle after the triggering edge, key_data_valid=1 and key_data = {ones, key_state}. key_data_valid is 0 on the following cycle.
- Press latency: 1 clk after the key_state update.
- Multi-key patterns (e.g. 5'h1c) are emitted unchanged; the downstream deframer rejects them.
- Release never produces an event.
- chg takes priority over repeat expiry on the same cycle.
- key_data_valid never asserts on two consecutive cycles.
- Reset mid-press: all state returns to reset values. A key still held after reset is re-debounced and produces a fresh event.
- Width: rcnt is sized to max(REPEAT_DLY, REPEAT_PERIOD). dcnt and the divider are sized to their parameters; no overflow is possible.

Test Plan (SAMPLE_DIV=4, DEBOUNCE_N=3, REPEAT_DLY=5, REPEAT_PERIOD=2, KEY_NUM=5):
1. Reset check: rst=1 for 3 cycles, then release -> key_data=16'hffff, key_data_valid=0, key_state=5'h1f.
2. Clean press: key_in=5'h1e held for 40 cycles.
   - Expected: exactly one key_data_valid pulse with key_data=16'hfffe, within 2+3*4+2 cycles of the change.
   - Then release key_in=5'h1f -> key_state returns to 5'h1f, no further pulse.
3. Bounce: toggle key_in bit 2 every 4 cycles (one tick) for 40 cycles, then hold at 1 -> no pulse, key_state stays 5'h1f.
4. Auto-repeat: hold key_in=5'h17.
   - Expected: first pulse with key_data=16'hfff7; next pulse 5 ticks (20 clk) later; then pulses every 2 ticks (8 clk), each with key_data=16'hfff7.
5. Pattern change and multi-key:
   - Hold 5'h1d until accepted, then change to 5'h1c while held -> pulses with key_data=16'hfffd, then 16'hfffc; the repeat delay restarts from 5 ticks.
   - Release -> no pulse, FSM returns to IDLE.
6. Reset mid-repeat: assert rst during REPT with 5'h0f held -> outputs return to reset values immediately. After rst=0 with the key still held, a single fresh pulse with key_data=16'hffef arrives after full debounce.

Source files
------------

// File: rtl/key_scan.sv
// Front-panel key scanner: synchronises active-low key lines, debounces them on a
// slow sample tick and emits one-cycle event strobes with optional auto-repeat.
module key_scan #(
  parameter int U_DLY         = 1,
  parameter int KEY_NUM       = 5,
  parameter int SAMPLE_DIV    = 50000,
  parameter int DEBOUNCE_N    = 20,
  parameter int REPEAT_DLY    = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [15:0]        key_data,
  output logic               key_data_valid
);

  localparam int DIV_W  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DCNT_W = (DEBOUNCE_N > 2) ? $clog2(DEBOUNCE_N) : 1;
  localparam int RMAX   = (REPEAT_DLY > REPEAT_PERIOD) ? REPEAT_DLY : REPEAT_PERIOD;
  localparam int RCNT_W = $clog2(RMAX + 1);

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);
  localparam logic [DCNT_W-1:0]  DCNT_MAX = DCNT_W'(DEBOUNCE_N - 1);
  localparam logic [DCNT_W-1:0]  DCNT_ACC = DCNT_W'(DEBOUNCE_N - 2);
  localparam logic [DCNT_W-1:0]  DCNT_ONE = DCNT_W'(1);
  localparam logic [RCNT_W-1:0]  RCNT_DLY = RCNT_W'(REPEAT_DLY);
  localparam logic [RCNT_W-1:0]  RCNT_PER = RCNT_W'(REPEAT_PERIOD);
  localparam logic [RCNT_W-1:0]  RCNT_ONE = RCNT_W'(1);
  localparam logic [KEY_NUM-1:0] ALL_UP   = {KEY_NUM{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_REPT = 2'd2
  } state_t;

  logic [KEY_NUM-1:0] sync_1;
  logic [KEY_NUM-1:0] sync_key;
  logic [KEY_NUM-1:0] cand;
  logic [DCNT_W-1:0]  dcnt;
  logic [DIV_W-1:0]   div;
  logic [RCNT_W-1:0]  rcnt;
  state_t             state;

  logic               tick;
  logic               chg;
  logic               rel;
  logic [15:0]        new_word;
  logic [15:0]        held_word;
  logic               unused_dly;

  // Register timing is modelled by the clock edge alone; U_DLY is kept for interface compatibility.
  assign unused_dly = (U_DLY != 0);

  // A new level is accepted on the DEBOUNCE_N-th consecutive tick that samples it.
  always_comb begin
    tick      = (div == DIV_LAST);
    chg       = tick && (sync_key == cand) && (dcnt >= DCNT_ACC) && (cand != key_state);
    rel       = (cand == ALL_UP);
    new_word  = 16'hffff;
    held_word = 16'hffff;
    new_word[KEY_NUM-1:0]  = cand;
    held_word[KEY_NUM-1:0] = key_state;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync_1    <= ALL_UP;
      sync_key  <= ALL_UP;
      cand      <= ALL_UP;
      dcnt      <= '0;
      div       <= '0;
      key_state <= ALL_UP;
    end else begin
      sync_1   <= key_in;
      sync_key <= sync_1;
      div      <= tick ? '0 : (div + DIV_ONE);
      if (tick) begin
        if (sync_key != cand) begin
          cand <= sync_key;
          dcnt <= '0;
        end else if (dcnt < DCNT_MAX) begin
          dcnt <= dcnt + DCNT_ONE;
        end
      end
      if (chg) begin
        key_state <= cand;
      end
    end
  end

  // Event FSM: a level change always wins over a repeat expiry on the same tick.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state          <= S_IDLE;
      rcnt           <= '0;
      key_data       <= 16'hffff;
      key_data_valid <= 1'b0;
    end else begin
      key_data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (chg && !rel) begin
            key_data_valid <= 1'b1;
            key_data       <= new_word;
            rcnt           <= RCNT_DLY;
            state          <= S_HOLD;
          end
        end
        S_HOLD, S_REPT: begin
          if (chg) begin
            if (rel) begin
              state <= S_IDLE;
            end else begin
              key_data_valid <= 1'b1;
              key_data       <= new_word;
              rcnt           <= RCNT_DLY;
              state          <= S_HOLD;
            end
          end else if (tick && (REPEAT_DLY != 0)) begin
            if (rcnt <= RCNT_ONE) begin
              key_data_valid <= 1'b1;
              key_data       <= held_word;
              rcnt           <= RCNT_PER;
              state          <= S_REPT;
            end else begin
              rcnt <= rcnt - RCNT_ONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
